// File: rtl/alu_muldiv.sv
// RV32M multiply/divide execution unit: fixed-latency multiply, restoring
// radix-2 divide, single-cycle special-case divides, one ROB-tagged result pulse.
module alu_muldiv #(
    parameter int XLEN      = 32,
    parameter int ROB_WIDTH = 4,
    parameter int MUL_LAT   = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 calc_enable,
    input  logic [2:0]           op,
    input  logic [XLEN-1:0]      lhs,
    input  logic [XLEN-1:0]      rhs,
    input  logic [ROB_WIDTH-1:0] rob_dep,
    output logic                 issue_ready,
    output logic                 ready,
    output logic [ROB_WIDTH-1:0] rob_id,
    output logic [XLEN-1:0]      value
);

    localparam int CNT_MAX = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [XLEN-1:0]  ZERO_X   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  ONES_X   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  MIN_X    = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    function automatic logic [XLEN-1:0] neg_f(input logic [XLEN-1:0] x);
        return ~x + ONE_X;
    endfunction

    state_t              state_r, state_next_s;
    logic [1:0]          op_r;
    logic [XLEN-1:0]     lhs_r, rhs_r;
    logic [ROB_WIDTH-1:0] tag_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                setup_r;
    logic [XLEN-1:0]     q_r, rem_r, d_r;

    logic                accept_s, finish_s, special_in_s;
    logic                signed_div_s, neg_q_s, neg_rem_s;
    logic                sa_s, sb_s;
    logic [2*XLEN-1:0]   mul_a_s, mul_b_s, prod_s;
    logic [XLEN:0]       rem_shift_s, diff_s;
    logic [XLEN-1:0]     rem_next_s, q_next_s;
    logic [XLEN-1:0]     mul_res_s, div_res_s, spec_res_s, result_s;

    assign issue_ready  = (state_r == ST_IDLE);
    assign special_in_s = (rhs == ZERO_X) || (!op[0] && (lhs == MIN_X) && (rhs == ONES_X));

    // Next-state decode, accept and completion strobes
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (calc_enable) begin
                    accept_s = 1'b1;
                    if (!op[2]) begin
                        state_next_s = ST_MUL;
                    end else if (special_in_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_DIV;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (cnt_r == CNT_ZERO) begin
                    state_next_s = ST_IDLE;
                    finish_s     = 1'b1;
                end else begin
                    state_next_s = ST_MUL;
                end
            end
            ST_DIV: begin
                if (!setup_r && (cnt_r == CNT_ZERO)) begin
                    state_next_s = ST_IDLE;
                    finish_s     = 1'b1;
                end else begin
                    state_next_s = ST_DIV;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
                finish_s     = 1'b1;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Multiply and divide datapaths plus final result selection
    always_comb begin
        // Sign-extending to 2*XLEN keeps the low 2*XLEN product bits exact for every signedness mix
        sa_s    = (op_r == 2'b01 || op_r == 2'b10) && lhs_r[XLEN-1];
        sb_s    = (op_r == 2'b01) && rhs_r[XLEN-1];
        mul_a_s = {{XLEN{sa_s}}, lhs_r};
        mul_b_s = {{XLEN{sb_s}}, rhs_r};
        prod_s  = mul_a_s * mul_b_s;
        if (op_r == 2'b00) begin
            mul_res_s = prod_s[XLEN-1:0];
        end else begin
            mul_res_s = prod_s[2*XLEN-1:XLEN];
        end

        signed_div_s = !op_r[0];
        neg_q_s      = signed_div_s && (lhs_r[XLEN-1] ^ rhs_r[XLEN-1]);
        neg_rem_s    = signed_div_s && lhs_r[XLEN-1];
        rem_shift_s  = {rem_r, q_r[XLEN-1]};
        diff_s       = rem_shift_s - {1'b0, d_r};
        if (!diff_s[XLEN]) begin
            rem_next_s = diff_s[XLEN-1:0];
            q_next_s   = {q_r[XLEN-2:0], 1'b1};
        end else begin
            rem_next_s = rem_shift_s[XLEN-1:0];
            q_next_s   = {q_r[XLEN-2:0], 1'b0};
        end
        if (op_r[1]) begin
            div_res_s = neg_rem_s ? neg_f(rem_next_s) : rem_next_s;
        end else begin
            div_res_s = neg_q_s ? neg_f(q_next_s) : q_next_s;
        end

        if (rhs_r == ZERO_X) begin
            spec_res_s = op_r[1] ? lhs_r : ONES_X;
        end else begin
            spec_res_s = op_r[1] ? ZERO_X : lhs_r;
        end

        case (state_r)
            ST_MUL:  result_s = mul_res_s;
            ST_DIV:  result_s = div_res_s;
            ST_DONE: result_s = spec_res_s;
            default: result_s = ZERO_X;
        endcase
    end

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r <= ST_IDLE;
        end else if (rdy_in) begin
            state_r <= clear ? ST_IDLE : state_next_s;
        end
    end

    // Operand capture, iteration registers and registered result outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ready   <= 1'b0;
            rob_id  <= {ROB_WIDTH{1'b0}};
            value   <= ZERO_X;
            op_r    <= 2'b00;
            lhs_r   <= ZERO_X;
            rhs_r   <= ZERO_X;
            tag_r   <= {ROB_WIDTH{1'b0}};
            cnt_r   <= CNT_ZERO;
            setup_r <= 1'b0;
            q_r     <= ZERO_X;
            rem_r   <= ZERO_X;
            d_r     <= ZERO_X;
        end else if (rdy_in) begin
            if (clear) begin
                ready   <= 1'b0;
                rob_id  <= {ROB_WIDTH{1'b0}};
                value   <= ZERO_X;
                cnt_r   <= CNT_ZERO;
                setup_r <= 1'b0;
            end else begin
                ready <= finish_s;
                if (finish_s) begin
                    rob_id <= tag_r;
                    value  <= result_s;
                end
                if (accept_s) begin
                    op_r    <= op[1:0];
                    lhs_r   <= lhs;
                    rhs_r   <= rhs;
                    tag_r   <= rob_dep;
                    cnt_r   <= op[2] ? DIV_INIT : MUL_INIT;
                    setup_r <= op[2];
                end else if (state_r == ST_MUL) begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end else if (state_r == ST_DIV) begin
                    if (setup_r) begin
                        setup_r <= 1'b0;
                        rem_r   <= ZERO_X;
                        q_r     <= (signed_div_s && lhs_r[XLEN-1]) ? neg_f(lhs_r) : lhs_r;
                        d_r     <= (signed_div_s && rhs_r[XLEN-1]) ? neg_f(rhs_r) : rhs_r;
                    end else begin
                        q_r   <= q_next_s;
                        rem_r <= rem_next_s;
                        if (cnt_r != CNT_ZERO) begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                end
            end
        end
    end

endmodule
